servant_boot_ctrl: RTL and testbench
====================================

Name: servant_boot_ctrl

Overview:
Boot/debug sequencer that drives the SPI port of the RAM arbiter. It takes a command stream decoded from the SPI register bank, performs Wishbone word writes and reads into servant RAM, and holds or releases CPU reset. It lets a host load a program over SPI while the CPU is halted, then start the CPU.

Parameters:
BOOT_HALTED, 1, reset value of o_cpu_reset (1 = CPU held in reset after i_rst)
TIMEOUT, 255, max cycles waiting for i_wb_ack before abort (1..65535)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
i_clk  in  1  system clock (wb_clk)
i_rst  in  1  synchronous active-high reset
i_cmd_valid  in  1  command valid
o_cmd_ready  out  1  command accepted when valid&ready
i_cmd_op  in  2  00 SET_ADDR, 01 WRITE, 10 READ, 11 RUN
i_cmd_data  in  32  address / write data / run flag (bit0)
o_rsp_valid  out  1  read response valid
i_rsp_ready  in  1  response consumed when valid&ready
o_rsp_data  out  32  read data
o_err  out  1  sticky bus-timeout flag
o_wb_adr  out  32  Wishbone address, bits[1:0] always 0
o_wb_dat  out  32  write data
o_wb_sel  out  4  always 4'hF while cyc
o_wb_we  out  1  write enable
o_wb_cyc  out  1  cycle/strobe
i_wb_rdt  in  32  read data
i_wb_ack  in  1  single-cycle acknowledge
o_cpu_reset  out  1  to CPU reset OR tree

Behaviour:
- Single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: state IDLE, addr=0, o_wb_cyc=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_rsp_valid=0, o_rsp_data=0, o_err=0, o_cpu_reset=BOOT_HALTED, timeout counter=0.
- FSM states:
  - IDLE: o_cmd_ready=1. On accept:
    - SET_ADDR: addr<={data[31:2],2'b0}; stays IDLE.
    - RUN: o_cpu_reset<=~data[0]; stays IDLE.
    - WRITE: latch data; ->BUS with cyc=1, we=1.
    - READ: ->BUS with cyc=1, we=0.
  - BUS: o_cmd_ready=0; cyc, adr, dat, we and sel are held stable.
    - On i_wb_ack: cyc<=0 and addr<=addr+4 (32-bit wrap, FFFF_FFFC->0). WRITE goes to IDLE. READ latches i_wb_rdt into o_rsp_data and goes to RSP.
    - Counter increments each BUS cycle. On reaching TIMEOUT with no ack: cyc<=0, o_err<=1, addr still increments. READ goes to RSP with o_rsp_data=ERR_DATA; WRITE goes to IDLE.
  - RSP: o_rsp_valid=1, o_cmd_ready=0. On i_rsp_ready: ->IDLE, valid<=0.
- Latency:
  - WRITE accept to cyc rise: 1 cycle.
  - Ack to next o_cmd_ready: 1 cycle.
  - READ ack to o_rsp_valid: 1 cycle.
- i_wb_ack outside BUS is ignored. o_err clears only on i_rst.
- RUN is legal at any time in IDLE, including while the CPU runs. CPU dbus accesses are arbitrated externally.
- i_rst mid-BUS drops cyc in the next cycle. Any pending response is discarded.
- Commands are never dropped: valid with ready=0 stalls the source.

Optional Feature:
SERVANT_BOOT_CSUM_EN: adds output o_csum[31:0], reset 0.
- Each acked WRITE adds its data modulo 2^32.
- SET_ADDR clears o_csum.
- Timed-out writes do not add.
Without the macro, the port and adder are absent and behaviour is otherwise identical.

Test Plan:
- Reset with BOOT_HALTED=1 -> o_cpu_reset=1, o_cmd_ready=1, o_wb_cyc=0, o_err=0.
- SET_ADDR 0x103, WRITE 0xA5A5_0001, WRITE 0x0000_0002, ack after 2 cycles each -> writes to adr 0x100 then 0x104, sel=F, we=1. With SERVANT_BOOT_CSUM_EN, o_csum=0xA5A5_0003.
- SET_ADDR 0x100, READ with i_wb_rdt=0x1234_5678 -> o_rsp_data=0x1234_5678, o_rsp_valid held 3 cycles while i_rsp_ready=0, then cleared; next address 0x104.
- READ with ack never given, TIMEOUT=4 -> cyc drops after 4 cycles, o_err=1, o_rsp_data=0xDEAD_BEEF, sticky across later good commands.
- SET_ADDR 0xFFFF_FFFC, WRITE acked -> next WRITE goes to adr 0x0000_0000.
- RUN data=1 -> o_cpu_reset=0 next cycle. RUN data=0 -> 1. i_rst asserted mid-BUS -> cyc=0 next cycle, state IDLE, o_cpu_reset=BOOT_HALTED.

Source files
------------

// File: rtl/servant_boot_ctrl.sv
// servant_boot_ctrl: SPI-driven boot/debug sequencer for servant RAM.
// Runs SET_ADDR/WRITE/READ/RUN commands as Wishbone word accesses and
// controls the CPU reset line.
// Optional macro SERVANT_BOOT_CSUM_EN adds an o_csum running sum of acked writes.
module servant_boot_ctrl #(
  parameter bit          BOOT_HALTED = 1'b1,
  parameter int unsigned TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd_op,
  input  logic [31:0] i_cmd_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_err,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic        o_cpu_reset
`ifdef SERVANT_BOOT_CSUM_EN
  ,
  output logic [31:0] o_csum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RSP} state_t;
  typedef enum logic [1:0] {
    OP_SET_ADDR = 2'b00,
    OP_WRITE    = 2'b01,
    OP_READ     = 2'b10,
    OP_RUN      = 2'b11
  } op_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  op_t         cmd_op;
  logic [31:0] addr;
  logic [15:0] tmo_cnt;
  logic        cmd_fire;
  logic        bus_done;

  assign cmd_op   = op_t'(i_cmd_op);
  assign cmd_fire = i_cmd_valid & o_cmd_ready;
  // A bus access ends on ack or on the last permitted wait cycle.
  assign bus_done = (state == S_BUS) & (i_wb_ack | (tmo_cnt == TMO_LAST));
  assign o_wb_sel = {4{o_wb_cyc}};

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and command handshake.
  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    case (state)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid && (cmd_op == OP_WRITE || cmd_op == OP_READ))
          state_nxt = S_BUS;
      end
      S_BUS: begin
        if (bus_done) state_nxt = o_wb_we ? S_IDLE : S_RSP;
      end
      S_RSP: begin
        if (i_rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address pointer, bus signals, response, error and CPU reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr        <= '0;
      tmo_cnt     <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_adr    <= '0;
      o_wb_dat    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_err       <= 1'b0;
      o_cpu_reset <= BOOT_HALTED;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_SET_ADDR: addr <= {i_cmd_data[31:2], 2'b00};
              OP_RUN:      o_cpu_reset <= ~i_cmd_data[0];
              OP_WRITE: begin
                o_wb_cyc <= 1'b1;
                o_wb_we  <= 1'b1;
                o_wb_adr <= addr;
                o_wb_dat <= i_cmd_data;
                tmo_cnt  <= '0;
              end
              default: begin
                o_wb_cyc <= 1'b1;
                o_wb_we  <= 1'b0;
                o_wb_adr <= addr;
                tmo_cnt  <= '0;
              end
            endcase
          end
        end
        S_BUS: begin
          if (bus_done) begin
            o_wb_cyc <= 1'b0;
            o_wb_we  <= 1'b0;
            addr     <= addr + 32'd4;
            if (!i_wb_ack) o_err <= 1'b1;
            if (!o_wb_we) begin
              o_rsp_valid <= 1'b1;
              o_rsp_data  <= i_wb_ack ? i_wb_rdt : ERR_DATA;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_RSP: begin
          if (i_rsp_ready) o_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef SERVANT_BOOT_CSUM_EN
  // Running sum of acknowledged write data; restarted by SET_ADDR.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_csum <= '0;
    else if (cmd_fire && cmd_op == OP_SET_ADDR)
      o_csum <= '0;
    else if (state == S_BUS && o_wb_we && i_wb_ack)
      o_csum <= o_csum + o_wb_dat;
  end
`endif

endmodule

// File: tb/tb_servant_boot_ctrl.sv
// Self-checking bench for servant_boot_ctrl with scoreboarded bus and
// response expectations.
module tb_servant_boot_ctrl;

  localparam int TMO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        err;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt = '0;
  logic        wb_ack = 1'b0;
  logic        cpu_reset;
`ifdef SERVANT_BOOT_CSUM_EN
  logic [31:0] csum;
`endif

  always #5 clk = ~clk;

  servant_boot_ctrl #(
    .BOOT_HALTED(1'b1),
    .TIMEOUT    (TMO),
    .ERR_DATA   (ERRD)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_data(cmd_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_err(err),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel),
    .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack),
    .o_cpu_reset(cpu_reset)
`ifdef SERVANT_BOOT_CSUM_EN
    , .o_csum(csum)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] m_addr = '0;
  logic [31:0] m_csum = '0;
  logic        m_err  = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command and update the reference model when it is accepted.
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] d);
    int   n;
    bus_t b;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept op=%0d ready=%b required 1", op, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    case (op)
      2'b00: begin m_addr = {d[31:2], 2'b00}; m_csum = '0; end
      2'b01: begin b.we = 1'b1; b.adr = m_addr; b.dat = d; bus_q.push_back(b); m_addr += 32'd4; end
      2'b10: begin b.we = 1'b0; b.adr = m_addr; b.dat = '0; bus_q.push_back(b); m_addr += 32'd4; end
      default: ;
    endcase
  endtask

  // Serve one Wishbone access: acked after 'delay' cycles, or left to time out.
  task automatic bus_service(input int delay, input bit do_ack, input logic [31:0] rdt);
    int   n;
    bus_t e;
    n = 0;
    while (!wb_cyc && n < 10) begin tick(); n++; end
    checks++;
    if (bus_q.size() == 0) begin
      errors++;
      $display("FAIL bus_scoreboard cyc=%b with no expected access", wb_cyc);
      return;
    end
    e = bus_q.pop_front();
    if (wb_cyc !== 1'b1 || wb_adr !== e.adr || wb_we !== e.we || wb_sel !== 4'hF ||
        (e.we && wb_dat !== e.dat)) begin
      errors++;
      $display("FAIL bus_access cyc=%b adr=%h we=%b sel=%h dat=%h required cyc=1 adr=%h we=%b sel=f dat=%h",
               wb_cyc, wb_adr, wb_we, wb_sel, wb_dat, e.adr, e.we, e.dat);
    end
    if (do_ack) begin
      repeat (delay) begin
        tick();
        checks++;
        if (wb_cyc !== 1'b1 || wb_adr !== e.adr || cmd_ready !== 1'b0) begin
          errors++;
          $display("FAIL bus_hold cyc=%b adr=%h ready=%b required cyc=1 adr=%h ready=0",
                   wb_cyc, wb_adr, cmd_ready, e.adr);
        end
      end
      wb_ack = 1'b1; wb_rdt = rdt;
      tick();
      wb_ack = 1'b0;
      if (e.we) m_csum += e.dat;
      else      rsp_q.push_back(rdt);
      checks++;
      if (wb_cyc !== 1'b0 || err !== m_err || (e.we && cmd_ready !== 1'b1)) begin
        errors++;
        $display("FAIL bus_end cyc=%b err=%b ready=%b required cyc=0 err=%b ready=%b",
                 wb_cyc, err, cmd_ready, m_err, e.we);
      end
    end else begin
      n = 0;
      while (wb_cyc && n < TMO + 5) begin n++; tick(); end
      m_err = 1'b1;
      if (!e.we) rsp_q.push_back(ERRD);
      checks++;
      if (n != TMO || err !== 1'b1) begin
        errors++;
        $display("FAIL bus_timeout cyc_cycles=%0d err=%b required cycles=%0d err=1", n, err, TMO);
      end
    end
  endtask

  // Consume one response after holding i_rsp_ready low for 'hold' extra cycles.
  task automatic rsp_check(input int hold);
    int          n;
    logic [31:0] exp;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    checks++;
    if (rsp_q.size() == 0) begin
      errors++;
      $display("FAIL rsp_scoreboard valid=%b with no expected response", rsp_valid);
      return;
    end
    exp = rsp_q.pop_front();
    if (rsp_valid !== 1'b1 || rsp_data !== exp) begin
      errors++;
      $display("FAIL rsp_data valid=%b data=%h required valid=1 data=%h", rsp_valid, rsp_data, exp);
    end
    repeat (hold) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL rsp_hold valid=%b data=%h ready=%b required valid=1 data=%h ready=0",
                 rsp_valid, rsp_data, cmd_ready, exp);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rsp_release valid=%b ready=%b required valid=0 ready=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    m_addr = '0; m_csum = '0; m_err = 1'b0;
    checks++;
    if (cpu_reset !== 1'b1 || cmd_ready !== 1'b1 || wb_cyc !== 1'b0 || err !== 1'b0 ||
        rsp_valid !== 1'b0 || wb_sel !== 4'h0 || wb_adr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state cpu_reset=%b ready=%b cyc=%b err=%b rsp_valid=%b sel=%h adr=%h required 1 1 0 0 0 0 0",
               cpu_reset, cmd_ready, wb_cyc, err, rsp_valid, wb_sel, wb_adr);
    end
  endtask

  task automatic test_write;
    send_cmd(2'b00, 32'h0000_0103);
    send_cmd(2'b01, 32'hA5A5_0001);
    bus_service(2, 1'b1, '0);
    send_cmd(2'b01, 32'h0000_0002);
    bus_service(2, 1'b1, '0);
`ifdef SERVANT_BOOT_CSUM_EN
    checks++;
    if (csum !== 32'hA5A5_0003) begin
      errors++;
      $display("FAIL write_csum csum=%h required a5a50003", csum);
    end
`endif
  endtask

  task automatic test_read;
    send_cmd(2'b00, 32'h0000_0100);
    send_cmd(2'b10, '0);
    bus_service(1, 1'b1, 32'h1234_5678);
    rsp_check(2);
    send_cmd(2'b10, '0);
    bus_service(0, 1'b1, 32'hCAFE_F00D);
    rsp_check(0);
  endtask

  task automatic test_timeout;
    send_cmd(2'b10, '0);
    bus_service(0, 1'b0, '0);
    rsp_check(1);
    send_cmd(2'b01, 32'h0000_0055);
    bus_service(0, 1'b0, '0);
    send_cmd(2'b01, 32'h0000_0011);
    bus_service(1, 1'b1, '0);
`ifdef SERVANT_BOOT_CSUM_EN
    checks++;
    if (csum !== m_csum) begin
      errors++;
      $display("FAIL timeout_csum csum=%h required %h", csum, m_csum);
    end
`endif
  endtask

  task automatic test_wrap;
    send_cmd(2'b00, 32'hFFFF_FFFC);
    send_cmd(2'b01, 32'h0000_0001);
    bus_service(0, 1'b1, '0);
    send_cmd(2'b01, 32'h0000_0002);
    bus_service(0, 1'b1, '0);
  endtask

  task automatic test_run;
    send_cmd(2'b11, 32'h0000_0001);
    checks++;
    if (cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL run_release cpu_reset=%b required 0", cpu_reset);
    end
    send_cmd(2'b11, 32'h0000_0000);
    checks++;
    if (cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL run_halt cpu_reset=%b required 1", cpu_reset);
    end
    send_cmd(2'b11, 32'h0000_0001);
    wb_ack = 1'b1;
    tick();
    wb_ack = 1'b0;
    checks++;
    if (wb_cyc !== 1'b0 || cmd_ready !== 1'b1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack cyc=%b ready=%b cpu_reset=%b required 0 1 0", wb_cyc, cmd_ready, cpu_reset);
    end
    send_cmd(2'b01, 32'h0000_0033);
    bus_service(0, 1'b1, '0);
  endtask

  task automatic test_rst_mid_bus;
    bus_t e;
    send_cmd(2'b01, 32'h0000_0077);
    e = bus_q.pop_front();
    checks++;
    if (wb_cyc !== 1'b1 || wb_adr !== e.adr) begin
      errors++;
      $display("FAIL rst_bus_start cyc=%b adr=%h required 1 %h", wb_cyc, wb_adr, e.adr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_addr = '0; m_csum = '0; m_err = 1'b0;
    checks++;
    if (wb_cyc !== 1'b0 || cmd_ready !== 1'b1 || cpu_reset !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_bus cyc=%b ready=%b cpu_reset=%b err=%b required 0 1 1 0",
               wb_cyc, cmd_ready, cpu_reset, err);
    end
    send_cmd(2'b10, '0);
    bus_service(0, 1'b1, 32'h0BAD_0BAD);
    void'(rsp_q.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_addr = '0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_rsp_discard valid=%b ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    send_cmd(2'b01, 32'h0000_0099);
    bus_service(1, 1'b1, '0);
  endtask

  initial begin
    tick();
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_wrap();
    test_run();
    test_rst_mid_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
